nios_dual_slave_ram: RTL and testbench

//  Parametrised on-chip RAM for the Nios system, the next generation of the single-port program/data memory.
//  Two Avalon-MM slaves (s1, s2) share one inferred single-port RAM.
//  A round-robin arbiter grants at most one access per cycle and stalls the loser with waitrequest.

---
 rtl/nios_dual_slave_ram.sv | 138 +++++++++++++
 tb/tb_nios_dual_slave_ram.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_dual_slave_ram.sv
// Dual Avalon-MM slave front end over one inferred single-port RAM.
// Round-robin arbitration, pipelined reads with READ_LATENCY of 1 or 2.
module nios_dual_slave_ram #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DEPTH        = 5346,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "Nios_memory.hex"
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clken,
    input  logic                   reset_req,
    input  logic [ADDR_W-1:0]      s1_address,
    input  logic [DATA_W/8-1:0]    s1_byteenable,
    input  logic                   s1_chipselect,
    input  logic                   s1_read,
    input  logic                   s1_write,
    input  logic [DATA_W-1:0]      s1_writedata,
    output logic                   s1_waitrequest,
    output logic [DATA_W-1:0]      s1_readdata,
    output logic                   s1_readdatavalid,
    input  logic [ADDR_W-1:0]      s2_address,
    input  logic [DATA_W/8-1:0]    s2_byteenable,
    input  logic                   s2_chipselect,
    input  logic                   s2_read,
    input  logic                   s2_write,
    input  logic [DATA_W-1:0]      s2_writedata,
    output logic                   s2_waitrequest,
    output logic [DATA_W-1:0]      s2_readdata,
    output logic                   s2_readdatavalid
);

    localparam int unsigned    BE_W    = DATA_W / 8;
    localparam int unsigned    MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {PORT_S1, PORT_S2} port_e;

    port_e               last_q, last_d;
    logic                req1, req2, en, grant1, grant2;
    logic                acc_wr, acc_rd, in_range;
    port_e               acc_port;
    logic [ADDR_W-1:0]   acc_addr;
    logic [BE_W-1:0]     acc_be;
    logic [DATA_W-1:0]   acc_wdata;
    logic [MEM_AW-1:0]   mem_idx;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   ram_rd_q;

    logic                v1_q, v2_q;
    port_e               t1_q, t2_q;
    logic [DATA_W-1:0]   d2_q;
    logic                ret_v;
    port_e               ret_t;
    logic [DATA_W-1:0]   ret_d;
    logic                hit1, hit2;
    logic [DATA_W-1:0]   hold1_q, hold2_q;

    always_comb begin
        req1      = s1_chipselect & (s1_read | s1_write);
        req2      = s2_chipselect & (s2_read | s2_write);
        en        = clken & ~reset_req;
        grant1    = 1'b0;
        grant2    = 1'b0;
        last_d    = last_q;
        if (en) begin
            if (req1 && (!req2 || last_q == PORT_S2)) grant1 = 1'b1;
            else if (req2)                            grant2 = 1'b1;
        end
        if (grant1)      last_d = PORT_S1;
        else if (grant2) last_d = PORT_S2;

        acc_port  = grant2 ? PORT_S2 : PORT_S1;
        acc_addr  = grant2 ? s2_address : s1_address;
        acc_be    = grant2 ? s2_byteenable : s1_byteenable;
        acc_wdata = grant2 ? s2_writedata : s1_writedata;
        // write wins when read and write are raised together
        acc_wr    = (grant1 & s1_write) | (grant2 & s2_write);
        acc_rd    = (grant1 | grant2) & ~acc_wr;
        in_range  = {1'b0, acc_addr} < DEPTH_C;
        mem_idx   = acc_addr[MEM_AW-1:0];
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    always_ff @(posedge clk) begin
        if (acc_wr && in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (acc_be[b]) mem_q[mem_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
        end
        if (acc_rd) ram_rd_q <= in_range ? mem_q[mem_idx] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT_S2;
            v1_q   <= 1'b0;
            t1_q   <= PORT_S1;
            v2_q   <= 1'b0;
            t2_q   <= PORT_S1;
            d2_q   <= '0;
        end else begin
            last_q <= last_d;
            v1_q   <= acc_rd;
            t1_q   <= acc_port;
            v2_q   <= v1_q;
            t2_q   <= t1_q;
            d2_q   <= ram_rd_q;
        end
    end

    assign ret_v = (READ_LATENCY == 2) ? v2_q : v1_q;
    assign ret_t = (READ_LATENCY == 2) ? t2_q : t1_q;
    assign ret_d = (READ_LATENCY == 2) ? d2_q : ram_rd_q;
    assign hit1  = ret_v & (ret_t == PORT_S1);
    assign hit2  = ret_v & (ret_t == PORT_S2);

    // readdata shows the returning word during the pulse, then the held copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold1_q <= '0;
            hold2_q <= '0;
        end else begin
            if (hit1) hold1_q <= ret_d;
            if (hit2) hold2_q <= ret_d;
        end
    end

    assign s1_readdatavalid = hit1;
    assign s2_readdatavalid = hit2;
    assign s1_readdata      = hit1 ? ret_d : hold1_q;
    assign s2_readdata      = hit2 ? ret_d : hold2_q;

endmodule

// File: tb/tb_nios_dual_slave_ram.sv
// Bench for nios_dual_slave_ram: two instances (latency 1 and 2) share stimulus
// and are compared every cycle against a transaction-level memory model.
module tb_nios_dual_slave_ram;

    localparam int DEPTH = 5346;

    logic              clk = 1'b0;
    logic              reset_n, clken, reset_req;
    logic [1:0][12:0]  addr;
    logic [1:0][3:0]   be;
    logic [1:0]        cs, rd, wr;
    logic [1:0][31:0]  wd;
    logic [1:0]        wt_a, wt_b, vl_a, vl_b;
    logic [1:0][31:0]  rd_a, rd_b;

    always #5 clk = ~clk;

    nios_dual_slave_ram #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
        .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
        .s1_waitrequest(wt_a[0]), .s1_readdata(rd_a[0]), .s1_readdatavalid(vl_a[0]),
        .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
        .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
        .s2_waitrequest(wt_a[1]), .s2_readdata(rd_a[1]), .s2_readdatavalid(vl_a[1])
    );

    nios_dual_slave_ram #(.READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
        .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
        .s1_waitrequest(wt_b[0]), .s1_readdata(rd_b[0]), .s1_readdatavalid(vl_b[0]),
        .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
        .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
        .s2_waitrequest(wt_b[1]), .s2_readdata(rd_b[1]), .s2_readdatavalid(vl_b[1])
    );

    typedef struct {
        int unsigned due;
        int          port;
        logic [31:0] data;
    } ret_t;

    int unsigned checks = 0, failures = 0;
    int unsigned edge_n = 0;
    logic [31:0] mem_m [int];
    int          last_m;
    ret_t        q0 [$];
    ret_t        q1 [$];
    logic [31:0] hold_m [2][2];
    int unsigned vcount [2][2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(int p, bit r, bit w, int a, logic [3:0] b, logic [31:0] d);
        cs[p]   = r | w;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = 13'(a);
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic idle();
        cs = '0; rd = '0; wr = '0;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 2; p++) hold_m[l][p] = '0;
        last_m = 1;
    endtask

    // One clock cycle: called at a negedge with inputs already applied.
    task automatic step();
        bit    req [2];
        bit    g   [2];
        bit    en;
        bit    ev;
        int    a;
        ret_t  r;
        #1;
        en = clken && !reset_req;
        for (int p = 0; p < 2; p++) begin
            req[p] = cs[p] && (rd[p] || wr[p]);
            g[p]   = 1'b0;
        end
        if (en) begin
            if (req[0] && req[1]) g[1 - last_m] = 1'b1;
            else if (req[0])      g[0] = 1'b1;
            else if (req[1])      g[1] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("waitreq_lat1_s%0d", p + 1), 32'(wt_a[p]), 32'(req[p] && !g[p]));
            chk($sformatf("waitreq_lat2_s%0d", p + 1), 32'(wt_b[p]), 32'(req[p] && !g[p]));
        end
        @(posedge clk);
        edge_n++;
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                last_m = p;
                a = int'(addr[p]);
                if (wr[p]) begin
                    if (a < DEPTH)
                        for (int b = 0; b < 4; b++)
                            if (be[p][b]) mem_m[a][b*8 +: 8] = wd[p][b*8 +: 8];
                end else begin
                    r.port = p;
                    r.data = (a < DEPTH) ? mem_m[a] : 32'h0;
                    r.due  = edge_n;
                    q0.push_back(r);
                    r.due  = edge_n + 1;
                    q1.push_back(r);
                end
            end
        end
        #1;
        for (int p = 0; p < 2; p++) begin
            ev = (q0.size() > 0) && (q0[0].due == edge_n) && (q0[0].port == p);
            if (ev) hold_m[0][p] = q0[0].data;
            chk($sformatf("valid_lat1_s%0d", p + 1), 32'(vl_a[p]), 32'(ev));
            chk($sformatf("rdata_lat1_s%0d", p + 1), rd_a[p], hold_m[0][p]);
            ev = (q1.size() > 0) && (q1[0].due == edge_n) && (q1[0].port == p);
            if (ev) hold_m[1][p] = q1[0].data;
            chk($sformatf("valid_lat2_s%0d", p + 1), 32'(vl_b[p]), 32'(ev));
            chk($sformatf("rdata_lat2_s%0d", p + 1), rd_b[p], hold_m[1][p]);
            if (vl_a[p]) vcount[0][p]++;
            if (vl_b[p]) vcount[1][p]++;
        end
        if (q0.size() > 0 && q0[0].due == edge_n) void'(q0.pop_front());
        if (q1.size() > 0 && q1[0].due == edge_n) void'(q1.pop_front());
        @(negedge clk);
    endtask

    task automatic chk_all_zero(string nm);
        for (int p = 0; p < 2; p++) begin
            chk({nm, "_vld1"}, 32'(vl_a[p]), 32'h0);
            chk({nm, "_rd1"},  rd_a[p],      32'h0);
            chk({nm, "_vld2"}, 32'(vl_b[p]), 32'h0);
            chk({nm, "_rd2"},  rd_b[p],      32'h0);
        end
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16)  return r;
        if (r == 16) return DEPTH - 1;
        if (r == 17) return DEPTH;
        if (r == 18) return DEPTH + 3;
        return 8191;
    endfunction

    initial begin
        logic [31:0] old7;
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        addr = '0; be = '0; wd = '0;
        idle();
        model_reset();
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 2; p++) vcount[l][p] = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        reset_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 1, a, 4'hF, $urandom);
            step();
        end
        drive(1, 0, 1, DEPTH - 1, 4'hF, 32'hCAFE0001);
        step();
        idle();

        // reset while reads are in flight
        drive(0, 1, 0, 3, 4'h0, 32'h0);
        step();
        drive(1, 1, 0, 4, 4'h0, 32'h0);
        idle();
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset_midread");
        model_reset();
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();

        // contention right after reset: s1 must win first
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 2; p++) vcount[l][p] = 0;
        drive(0, 1, 0, 0, 4'h0, 32'h0);
        drive(1, 1, 0, 1, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("contend_s1_wait", 32'(wt_a[0]), 32'(i % 2));
            chk("contend_s2_wait", 32'(wt_a[1]), 32'(1 - (i % 2)));
            step();
        end
        idle();
        repeat (3) step();
        chk("contend_cnt_lat1_s1", vcount[0][0], 32'd3);
        chk("contend_cnt_lat1_s2", vcount[0][1], 32'd3);
        chk("contend_cnt_lat2_s1", vcount[1][0], 32'd3);
        chk("contend_cnt_lat2_s2", vcount[1][1], 32'd3);

        // byte-lane write then readback
        drive(0, 0, 1, 5, 4'b1111, 32'hDEADBEEF);
        step();
        drive(0, 0, 1, 5, 4'b0010, 32'h0000AA00);
        step();
        drive(0, 1, 0, 5, 4'h0, 32'h0);
        step();
        idle();
        chk("lanes_lat1", rd_a[0], 32'hDEADAAEF);
        step();
        chk("lanes_lat2", rd_b[0], 32'hDEADAAEF);
        step();

        // back-to-back reads from s2 alone
        for (int a = 10; a < 13; a++) begin
            drive(1, 1, 0, a, 4'h0, 32'h0);
            step();
        end
        idle();
        repeat (3) step();

        // stall with a read still in flight
        old7 = mem_m[7];
        drive(1, 1, 0, 8, 4'h0, 32'h0);
        step();
        idle();
        clken = 1'b0;
        drive(0, 0, 1, 7, 4'hF, 32'h11111111);
        #1;
        chk("stall_clken_wait", 32'(wt_a[0]), 32'h1);
        step();
        step();
        clken = 1'b1;
        reset_req = 1'b1;
        #1;
        chk("stall_rreq_wait", 32'(wt_b[0]), 32'h1);
        step();
        reset_req = 1'b0;
        drive(0, 1, 0, 7, 4'h0, 32'h0);
        step();
        idle();
        chk("stall_nochange", rd_a[0], old7);
        repeat (2) step();

        // out-of-range write and read
        drive(0, 0, 1, DEPTH, 4'hF, 32'h12345678);
        step();
        drive(0, 1, 0, DEPTH, 4'h0, 32'h0);
        step();
        chk("range_read_zero", rd_a[0], 32'h0);
        drive(0, 1, 0, DEPTH - 1, 4'h0, 32'h0);
        step();
        idle();
        chk("range_neighbour", rd_a[0], 32'hCAFE0001);
        repeat (2) step();

        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0)
                    drive(p, 1'($urandom), 1'($urandom), pick_addr(), 4'($urandom), $urandom);
                else begin
                    cs[p] = 1'b0; rd[p] = 1'($urandom); wr[p] = 1'($urandom);
                end
            end
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        clken = 1'b1;
        reset_req = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
